// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - VGA sync timing monitor: lock FSM, visible coordinates, pure-red pixel count
// Counters and edge registers advance only on pix_en; all outputs are registered.
module vga_sync_monitor #(
   parameter int H_SYNC  = 96,
   parameter int H_BACK  = 48,
   parameter int H_VIS   = 640,
   parameter int H_FRONT = 16,
   parameter int V_SYNC  = 2,
   parameter int V_BACK  = 33,
   parameter int V_VIS   = 480,
   parameter int V_FRONT = 10,
   parameter int H_TOTAL = H_SYNC + H_BACK + H_VIS + H_FRONT,
   parameter int V_TOTAL = V_SYNC + V_BACK + V_VIS + V_FRONT
) (
   input  logic        clk,
   input  logic        resetNot,
   input  logic        pix_en,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [3:0]  red,
   input  logic [3:0]  green,
   input  logic [3:0]  blue,
   output logic        locked,
   output logic [9:0]  mon_x,
   output logic [9:0]  mon_y,
   output logic        pix_valid,
   output logic        frame_done,
   output logic [18:0] red_count,
   output logic [7:0]  err_count
);
   localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_VIS - 1);
   localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_VIS - 1);
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] CNT_MAX = 10'h3FF;

   typedef enum logic [1:0] {SEEK = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
   logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic        v_arm_q, v_arm_d, skip_line_q, skip_line_d;
   logic [9:0]  mon_x_q, mon_x_d, mon_y_q, mon_y_d;
   logic        pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
   logic [18:0] acc_q, acc_d, acc_inc, red_count_q, red_count_d;
   logic [7:0]  err_count_q, err_count_d;
   logic        h_fall, v_fall, visible, pure_red, line_err, frame_err, red_hit;

   assign h_fall    = pix_en & hs_prev_q & ~hsync;
   assign v_fall    = pix_en & vs_prev_q & ~vsync;
   assign pure_red  = (red == 4'hF) && (green == 4'h0) && (blue == 4'h0);
   assign line_err  = h_fall & ~skip_line_q & (h_cnt_q != H_LAST);
   assign frame_err = v_fall & (v_cnt_q != V_LAST);
   assign hs_prev_d = pix_en ? hsync : hs_prev_q;
   assign vs_prev_d = pix_en ? vsync : vs_prev_q;

   // A vsync edge arriving together with the hsync edge counts as already armed,
   // so the line that starts with both edges is line 0.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      v_arm_d = v_arm_q;
      if (pix_en) begin
         h_cnt_d = h_fall ? 10'd0 : ((h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 10'd1);
         if (h_fall) begin
            v_cnt_d = (v_arm_q | v_fall) ? 10'd0 :
                      ((v_cnt_q == CNT_MAX) ? v_cnt_q : v_cnt_q + 10'd1);
            v_arm_d = 1'b0;
         end else begin
            v_arm_d = v_arm_q | v_fall;
         end
      end
   end

   assign visible = (h_cnt_d >= H_START) && (h_cnt_d <= H_END) &&
                    (v_cnt_d >= V_START) && (v_cnt_d <= V_END);
   assign red_hit = pix_en & visible & pure_red & (state_q == LOCKED);
   assign acc_inc = acc_q + {18'd0, red_hit};

   always_comb begin
      state_d      = state_q;
      skip_line_d  = skip_line_q;
      mon_x_d      = mon_x_q;
      mon_y_d      = mon_y_q;
      pix_valid_d  = pix_valid_q;
      frame_done_d = 1'b0;
      acc_d        = acc_q;
      red_count_d  = red_count_q;
      err_count_d  = err_count_q;
      if (pix_en) begin
         mon_x_d     = h_cnt_d - H_START;
         mon_y_d     = v_cnt_d - V_START;
         pix_valid_d = visible & (state_q == LOCKED);
         acc_d       = acc_inc;
         case (state_q)
            SEEK: begin
               if (v_fall) begin
                  state_d     = ALIGN;
                  skip_line_d = 1'b1;
               end
            end
            ALIGN, LOCKED: begin
               if (h_fall) skip_line_d = 1'b0;
               if (line_err | frame_err) begin
                  state_d     = SEEK;
                  acc_d       = 19'd0;
                  err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
               end else if (v_fall) begin
                  acc_d = 19'd0;
                  if (state_q == ALIGN) begin
                     state_d = LOCKED;
                  end else begin
                     red_count_d  = acc_inc;
                     frame_done_d = 1'b1;
                  end
               end
            end
            default: state_d = SEEK;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetNot) begin
      if (!resetNot) begin
         state_q      <= SEEK;
         hs_prev_q    <= 1'b1;
         vs_prev_q    <= 1'b1;
         h_cnt_q      <= 10'd0;
         v_cnt_q      <= 10'd0;
         v_arm_q      <= 1'b0;
         skip_line_q  <= 1'b0;
         mon_x_q      <= 10'd0;
         mon_y_q      <= 10'd0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         acc_q        <= 19'd0;
         red_count_q  <= 19'd0;
         err_count_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         hs_prev_q    <= hs_prev_d;
         vs_prev_q    <= vs_prev_d;
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         v_arm_q      <= v_arm_d;
         skip_line_q  <= skip_line_d;
         mon_x_q      <= mon_x_d;
         mon_y_q      <= mon_y_d;
         pix_valid_q  <= pix_valid_d;
         frame_done_q <= frame_done_d;
         acc_q        <= acc_d;
         red_count_q  <= red_count_d;
         err_count_q  <= err_count_d;
      end
   end

   assign locked     = (state_q == LOCKED);
   assign mon_x      = mon_x_q;
   assign mon_y      = mon_y_q;
   assign pix_valid  = pix_valid_q;
   assign frame_done = frame_done_q;
   assign red_count  = red_count_q;
   assign err_count  = err_count_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - randomized frame stimulus against a frame-level reference for vga_sync_monitor
module tb_vga_sync_monitor;
   localparam int HS = 3, HB = 2, HV = 42, HF = 1, HT = HS + HB + HV + HF;
   localparam int VS = 2, VB = 1, VV = 42, VF = 1, VT = VS + VB + VV + VF;

   logic        clk = 1'b0;
   logic        resetNot = 1'b0;
   logic        pix_en = 1'b0;
   logic        hsync = 1'b1, vsync = 1'b1;
   logic [3:0]  red = 4'h0, green = 4'h0, blue = 4'h0;
   logic        locked, pix_valid, frame_done;
   logic [9:0]  mon_x, mon_y;
   logic [18:0] red_count;
   logic [7:0]  err_count;

   int checks = 0, errors = 0, fd_count = 0;
   logic        cap_locked, cap_fd;
   logic [18:0] cap_red;
   logic [7:0]  cap_err;
   logic        st_locked, st_fd, lk_after_short;
   logic [18:0] st_red;
   logic [7:0]  st_err;
   int          frame_red, prev_red;

   vga_sync_monitor #(
      .H_SYNC(HS), .H_BACK(HB), .H_VIS(HV), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_VIS(VV), .V_FRONT(VF)
   ) dut (
      .clk(clk), .resetNot(resetNot), .pix_en(pix_en),
      .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
      .locked(locked), .mon_x(mon_x), .mon_y(mon_y), .pix_valid(pix_valid),
      .frame_done(frame_done), .red_count(red_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done === 1'b1) fd_count++;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic noise();
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      {red, green, blue} = 12'($urandom);
   endtask

   // One pixel on a pix_en cycle, then 1-2 idle clocks carrying garbage inputs.
   task automatic drive_pix(input logic hs, input logic vs, input logic [3:0] r,
                            input logic [3:0] g, input logic [3:0] b,
                            input bit ev, input int ex, input int ey);
      int n;
      hsync = hs; vsync = vs; red = r; green = g; blue = b; pix_en = 1'b1;
      @(posedge clk); #1;
      cap_locked = locked; cap_fd = frame_done; cap_red = red_count; cap_err = err_count;
      checks++;
      if (pix_valid !== ev) begin
         errors++;
         $display("FAIL pix_valid at x=%0d y=%0d: got %b expected %b", ex, ey, pix_valid, ev);
      end
      if (ev) begin
         checks++;
         if (mon_x !== ex[9:0] || mon_y !== ey[9:0]) begin
            errors++;
            $display("FAIL mon_xy: got %0d/%0d expected %0d/%0d", mon_x, mon_y, ex, ey);
         end
      end
      pix_en = 1'b0;
      noise();
      n = ($urandom_range(0, 7) == 0) ? 2 : 1;
      repeat (n) begin @(posedge clk); #1; noise(); end
   endtask

   // mode 0: 41x41 pure-red square on black; mode 1: random square over random colours.
   task automatic gen_frame(input int nlines, input int short_line, input bit lk_in, input int mode);
      bit lk, vis, insq;
      int plen, sx, sy, sz, x, y;
      logic hs, vs;
      logic [3:0] r, g, b;
      lk = lk_in; frame_red = 0;
      sx = 1; sy = 1; sz = 41;
      if (mode == 1) begin
         sz = $urandom_range(5, 30); sx = $urandom_range(0, HV - 1); sy = $urandom_range(0, VV - 1);
      end
      for (int l = 0; l < nlines; l++) begin
         plen = (l == short_line) ? HT - 1 : HT;
         if (short_line >= 0 && l == short_line + 1) lk = 1'b0;
         for (int p = 0; p < plen; p++) begin
            hs = (p >= HS); vs = (l >= VS);
            x = p - (HS + HB); y = l - (VS + VB);
            vis  = (x >= 0) && (x < HV) && (y >= 0) && (y < VV);
            insq = (x >= sx) && (x < sx + sz) && (y >= sy) && (y < sy + sz);
            if (insq && vis) {r, g, b} = 12'hF00;
            else if (mode == 0) {r, g, b} = 12'h000;
            else if ($urandom_range(0, 7) == 0) {r, g, b} = 12'hF00;
            else {r, g, b} = 12'($urandom);
            if (vis && lk && r == 4'hF && g == 4'h0 && b == 4'h0) frame_red++;
            drive_pix(hs, vs, r, g, b, vis && lk, x, y);
            if (l == 0 && p == 0) begin
               st_locked = cap_locked; st_fd = cap_fd; st_red = cap_red; st_err = cap_err;
            end
            if (short_line >= 0 && l == short_line + 1 && p == 0) lk_after_short = cap_locked;
         end
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      checks++;
      if (locked !== 1'b0 || mon_x !== 10'd0 || mon_y !== 10'd0 || pix_valid !== 1'b0 ||
          frame_done !== 1'b0 || red_count !== 19'd0 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL %s: got lk=%b x=%0d y=%0d pv=%b fd=%b red=%0d err=%0d expected all zero",
                  tag, locked, mon_x, mon_y, pix_valid, frame_done, red_count, err_count);
      end
   endtask

   task automatic expect_start(input string tag, input logic lk, input logic fd, input int rc);
      checks++;
      if (st_locked !== lk || st_fd !== fd || st_red !== rc[18:0]) begin
         errors++;
         $display("FAIL %s: got locked=%b frame_done=%b red_count=%0d expected %b %b %0d",
                  tag, st_locked, st_fd, st_red, lk, fd, rc);
      end
   endtask

   task automatic test_reset();
      resetNot = 1'b0; pix_en = 1'b0;
      repeat (3) begin @(posedge clk); #1; noise(); end
      check_zero_outputs("reset_state");
      resetNot = 1'b1;
   endtask

   task automatic test_lock_sequence();
      gen_frame(VT, -1, 1'b0, 0);
      expect_start("edge1_align", 1'b0, 1'b0, 0);
      gen_frame(VT, -1, 1'b1, 0);
      expect_start("edge2_lock", 1'b1, 1'b0, 0);
      gen_frame(VT, -1, 1'b1, 0);
      expect_start("edge3_frame_done", 1'b1, 1'b1, 1681);
      checks++;
      if (st_err !== 8'd0) begin
         errors++;
         $display("FAIL lock_err_count: got %0d expected 0", st_err);
      end
      prev_red = frame_red;
   endtask

   task automatic test_random_red();
      gen_frame(VT, -1, 1'b1, 1);
      expect_start("square_red_count", 1'b1, 1'b1, prev_red);
      prev_red = frame_red;
   endtask

   task automatic test_reset_mid_frame();
      gen_frame(VT / 2, -1, 1'b1, 1);
      expect_start("random_red_count", 1'b1, 1'b1, prev_red);
      #2 resetNot = 1'b0;
      #1 check_zero_outputs("async_reset");
      @(posedge clk); #1;
      resetNot = 1'b1;
      gen_frame(VT, -1, 1'b0, 1);
      expect_start("post_reset_align", 1'b0, 1'b0, 0);
      gen_frame(VT, -1, 1'b1, 1);
      expect_start("post_reset_lock", 1'b1, 1'b0, 0);
      prev_red = frame_red;
   endtask

   task automatic test_line_error();
      gen_frame(VT, VS + VB + 5, 1'b1, 1);
      expect_start("line_err_frame_start", 1'b1, 1'b1, prev_red);
      checks++;
      if (lk_after_short !== 1'b0) begin
         errors++;
         $display("FAIL line_err_unlock: got locked=%b expected 0", lk_after_short);
      end
      checks++;
      if (err_count !== 8'd1 || red_count !== prev_red[18:0] || locked !== 1'b0) begin
         errors++;
         $display("FAIL line_err_after: got err=%0d red=%0d lk=%b expected 1 %0d 0",
                  err_count, red_count, locked, prev_red);
      end
      gen_frame(VT, -1, 1'b0, 1);
      expect_start("relock_align", 1'b0, 1'b0, prev_red);
   endtask

   task automatic test_frame_error();
      gen_frame(VT - 1, -1, 1'b1, 1);
      expect_start("relock_locked", 1'b1, 1'b0, prev_red);
      gen_frame(1, -1, 1'b0, 0);
      expect_start("frame_err_edge", 1'b0, 1'b0, prev_red);
      checks++;
      if (st_err !== 8'd2) begin
         errors++;
         $display("FAIL frame_err_count: got %0d expected 2", st_err);
      end
      checks++;
      if (fd_count != 4) begin
         errors++;
         $display("FAIL frame_done_pulses: got %0d expected 4", fd_count);
      end
   endtask

   task automatic test_err_saturation();
      resetNot = 1'b0;
      @(posedge clk); #1;
      check_zero_outputs("reset_before_sat");
      resetNot = 1'b1;
      for (int i = 0; i < 300; i++) begin
         drive_pix(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0);
         drive_pix(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0);
         drive_pix(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0);
         drive_pix(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 0, 0);
         if (i == 99 || i == 253 || i == 254 || i == 299) begin
            checks++;
            if (err_count !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
               errors++;
               $display("FAIL err_saturation after %0d errors: got %0d expected %0d",
                        i + 1, err_count, (i + 1 > 255) ? 255 : i + 1);
            end
         end
      end
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL sat_locked: got %b expected 0", locked);
      end
   endtask

   initial begin
      test_reset();
      test_lock_sequence();
      test_random_red();
      test_reset_mid_frame();
      test_line_error();
      test_frame_error();
      test_err_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameters (name, default, meaning): H_SYNC 96 hsync pulse pixels; H_BACK 48 back porch; H_VIS 640 visible pixels; H_FRONT 16 front porch; V_SYNC 2, V_BACK 33, V_VIS 480, V_FRONT 10, same in lines; H_TOTAL and V_TOTAL are the respective sums (800, 525).
REQ-002 clk  in  1  system clock; all state updates on posedge.
REQ-003 resetNot  in  1  asynchronous, active-low reset.
REQ-004 pix_en  in  1  pixel-rate enable (one clk in two); all sampling and counting occurs only when pix_en=1.
REQ-005 hsync, vsync  in  1 each  active-low sync from the VGA generator.
REQ-006 red, green, blue  in  4 each  pixel colour.
REQ-007 locked  out  1  timing lock achieved.
REQ-008 mon_x  out  10  visible column 0..639; mon_y  out  10  visible row 0..479.
REQ-009 pix_valid  out  1  high when the sampled pixel is visible and locked=1.
REQ-010 frame_done  out  1  one-clk pulse at each vsync falling edge while locked.
REQ-011 red_count  out  19  count of pure-red pixels in the last complete locked frame.
REQ-012 err_count  out  8  saturating count of timing errors since reset.

Function
REQ-013 Sync edges SHALL be detected by comparing the current sample with a registered previous sample taken on pix_en; a falling edge is prev=1, cur=0.
REQ-014 h_cnt (10 bit) SHALL be 0 on the pix_en cycle carrying an hsync falling edge and SHALL otherwise increment per pix_en, saturating at 1023.
REQ-015 A vsync falling edge SHALL arm v_arm; the next hsync falling edge SHALL set v_cnt=0 and clear v_arm; otherwise each hsync falling edge increments v_cnt, saturating at 1023.
REQ-016 Visible region: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VIS-1] (144..783) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VIS-1] (35..514); mon_x = h_cnt-144, mon_y = v_cnt-35, both registered, one pix_en cycle latency from the sampled inputs.
REQ-017 FSM states: SEEK, ALIGN, LOCKED.
REQ-018 SEEK -> ALIGN on first vsync falling edge; no error checks in SEEK.
REQ-019 ALIGN: line-length and frame-length checks active; ALIGN -> LOCKED on the next vsync falling edge if no error occurred since entering ALIGN.
REQ-020 Line error: hsync falling edge with previous h_cnt != H_TOTAL-1 (ignored on the first hsync edge after leaving SEEK).
REQ-021 Frame error: vsync falling edge with v_cnt != V_TOTAL-1.
REQ-022 Any error in ALIGN or LOCKED SHALL force SEEK next cycle and increment err_count (saturate at 255); line and frame error in the same cycle count once.
REQ-023 locked = 1 only in LOCKED.
REQ-024 Pure red = red=4'hF, green=0, blue=0; the frame accumulator SHALL increment on each pix_valid pure-red pixel.
REQ-025 On vsync falling edge in LOCKED with no error: red_count <= accumulator (including a pixel counted in the same cycle), accumulator <= 0, frame_done pulses.
REQ-026 On vsync falling edge in ALIGN: accumulator cleared, red_count unchanged, no frame_done.
REQ-027 Loss of lock SHALL clear the accumulator and hold red_count at its last value.
REQ-028 pix_en=0 SHALL freeze all counters, edge registers and FSM.

Reset
REQ-029 resetNot=0 SHALL immediately set state=SEEK, locked=0, mon_x=0, mon_y=0, pix_valid=0, frame_done=0, red_count=0, err_count=0, h_cnt=0, v_cnt=0, v_arm=0, accumulator=0, and sync edge registers=1.
REQ-030 Reset assertion mid-frame SHALL abort lock; after release the block SHALL require one vsync edge plus one clean frame before locked=1.

Verification
REQ-031 Ideal 640x480 timing, 3 frames from reset -> locked rises at second vsync falling edge; frame_done pulses at third; err_count=0.
REQ-032 Locked; bird square 41x41 pure red drawn each frame -> red_count=1681 after each frame_done.
REQ-033 Locked; one line shortened to 799 pixels -> locked falls next cycle, err_count=1, red_count holds, relock after two further vsync edges.
REQ-034 Locked; frame of 524 lines -> frame error, err_count increments by 1, no frame_done for that edge.
REQ-035 Pixel at h_cnt=144,v_cnt=35 and at 783,514 -> mon_x/mon_y = 0/0 and 639/479 with pix_valid=1; h_cnt=784 -> pix_valid=0.
REQ-036 resetNot pulsed low mid-frame while locked -> all outputs zero asynchronously; 300 injected errors -> err_count stays 255.
